// File: rtl/multi_alarm_ctrl_pkg.sv
// Shared types and constants for the multi-slot alarm controller.
// Holds the FSM encoding, the day length and the default snooze/ring timing.
package multi_alarm_ctrl_pkg;

  localparam int unsigned SECONDS_PER_DAY          = 86400;
  localparam int unsigned DEFAULT_SNOOZE_SEC       = 300;
  localparam int unsigned DEFAULT_RING_TIMEOUT_SEC = 60;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRinging = 2'd1,
    StSnooze  = 2'd2
  } alarm_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Slot index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_alarm_ctrl_prio_enc.sv
// Lowest-index-first priority encoder used to pick the next pending alarm slot.
module prio_enc #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_alarm_ctrl.sv
// Multi-slot alarm clock controller: per-slot time/enable storage, pending match latch,
// and an IDLE/RINGING/SNOOZE sequencer with saturating ring-timeout and snooze counters.
module multi_alarm_ctrl
  import multi_alarm_ctrl_pkg::*;
#(
  parameter int unsigned N_ALARM          = 4,
  parameter int unsigned TW               = 17,
  parameter int unsigned SNOOZE_SEC       = DEFAULT_SNOOZE_SEC,
  parameter int unsigned RING_TIMEOUT_SEC = DEFAULT_RING_TIMEOUT_SEC,
  localparam int unsigned IW              = idx_width(N_ALARM)
) (
  input  logic               RESETN,
  input  logic               CLK,
  input  logic               SEC_TICK,
  input  logic [TW-1:0]      CURRENT_TIME,
  input  logic               WR_EN,
  input  logic [IW-1:0]      WR_IDX,
  input  logic [TW-1:0]      WR_TIME,
  input  logic               WR_ENA,
  input  logic               ACK_STOP,
  input  logic               ACK_SNOOZE,
  output logic               ALARM_DOING,
  output logic [IW-1:0]      ALARM_IDX,
  output logic               SNOOZE_ACTIVE,
  output logic [N_ALARM-1:0] ENABLE_MASK
);

  localparam int unsigned CW = $clog2(max_u(SNOOZE_SEC, RING_TIMEOUT_SEC) + 1);

  typedef logic [CW-1:0] cnt_t;

  alarm_state_e               state_q, state_d;
  logic [N_ALARM-1:0][TW-1:0] time_q, time_d;
  logic [N_ALARM-1:0]         en_q, en_d;
  logic [N_ALARM-1:0]         pending_q, pending_d;
  logic [N_ALARM-1:0]         match, pend;
  logic [IW-1:0]              idx_q, idx_d;
  logic [IW-1:0]              sel;
  logic                       sel_valid;
  cnt_t                       ring_cnt_q, ring_cnt_d, ring_inc;
  cnt_t                       snz_cnt_q, snz_cnt_d, snz_inc;
  logic                       doing_q, snooze_q;
  logic                       wr_ok, wr_hit_active;

  assign wr_ok = WR_EN && (32'(WR_IDX) < N_ALARM) && (32'(WR_TIME) < SECONDS_PER_DAY);

  // Rewriting the slot that is currently ringing or snoozing aborts it.
  assign wr_hit_active = wr_ok && (WR_IDX == idx_q) && (state_q != StIdle);

  assign ring_inc = (ring_cnt_q == '1) ? ring_cnt_q : ring_cnt_q + 1'b1;
  assign snz_inc  = (snz_cnt_q == '1) ? snz_cnt_q : snz_cnt_q + 1'b1;

  always_comb begin
    match = '0;
    for (int i = 0; i < N_ALARM; i++) begin
      match[i] = SEC_TICK && en_q[i] && (time_q[i] == CURRENT_TIME);
    end
  end

  // Slot updates and the pending set after this cycle's matches and write-side clears.
  always_comb begin
    time_d = time_q;
    en_d   = en_q;
    pend   = pending_q | match;
    for (int i = 0; i < N_ALARM; i++) begin
      if (wr_ok && (WR_IDX == IW'(i))) begin
        time_d[i] = WR_TIME;
        en_d[i]   = WR_ENA;
        if (!WR_ENA) begin
          pend[i] = 1'b0;
        end
      end
      if (wr_hit_active && (idx_q == IW'(i))) begin
        pend[i] = 1'b0;
      end
    end
  end

  prio_enc #(
    .N  (N_ALARM),
    .IW (IW)
  ) u_prio_enc (
    .req   (pend),
    .idx   (sel),
    .valid (sel_valid)
  );

  // Keys are resolved before the tick, so a tick alongside an ACK never advances a counter.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    pending_d  = pend;
    case (state_q)
      StIdle: begin
        if (sel_valid) begin
          state_d    = StRinging;
          idx_d      = sel;
          ring_cnt_d = '0;
          for (int i = 0; i < N_ALARM; i++) begin
            if (sel == IW'(i)) begin
              pending_d[i] = 1'b0;
            end
          end
        end
      end
      StRinging: begin
        if (wr_hit_active || ACK_STOP) begin
          state_d = StIdle;
        end else if (ACK_SNOOZE) begin
          state_d   = StSnooze;
          snz_cnt_d = '0;
        end else if (SEC_TICK) begin
          ring_cnt_d = ring_inc;
          if (32'(ring_inc) >= RING_TIMEOUT_SEC) begin
            state_d = StIdle;
          end
        end
      end
      StSnooze: begin
        if (wr_hit_active || ACK_STOP) begin
          state_d = StIdle;
        end else if (SEC_TICK) begin
          snz_cnt_d = snz_inc;
          if (32'(snz_inc) >= SNOOZE_SEC) begin
            state_d    = StRinging;
            ring_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      pending_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      pending_q  <= pending_d;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      time_q <= '0;
      en_q   <= '0;
    end else begin
      time_q <= time_d;
      en_q   <= en_d;
    end
  end

  // Flag outputs track the next state so they change on the same edge as the FSM.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      doing_q  <= 1'b0;
      snooze_q <= 1'b0;
    end else begin
      doing_q  <= (state_d == StRinging);
      snooze_q <= (state_d == StSnooze);
    end
  end

  assign ALARM_DOING   = doing_q;
  assign SNOOZE_ACTIVE = snooze_q;
  assign ALARM_IDX     = idx_q;
  assign ENABLE_MASK   = en_q;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed bench for multi_alarm_ctrl: ringing, priority, snooze, timeout, key precedence,
// pending re-arm, write-abort and asynchronous reset, checked against hand-computed values.
module tb_multi_alarm_ctrl;

  logic        RESETN;
  logic        CLK;
  logic        SEC_TICK;
  logic [16:0] CURRENT_TIME;
  logic        WR_EN;
  logic [1:0]  WR_IDX;
  logic [16:0] WR_TIME;
  logic        WR_ENA;
  logic        ACK_STOP;
  logic        ACK_SNOOZE;
  logic        ALARM_DOING;
  logic [1:0]  ALARM_IDX;
  logic        SNOOZE_ACTIVE;
  logic [3:0]  ENABLE_MASK;

  int total;
  int bad;

  multi_alarm_ctrl #(
    .N_ALARM          (4),
    .TW               (17),
    .SNOOZE_SEC       (300),
    .RING_TIMEOUT_SEC (60)
  ) dut (
    .RESETN        (RESETN),
    .CLK           (CLK),
    .SEC_TICK      (SEC_TICK),
    .CURRENT_TIME  (CURRENT_TIME),
    .WR_EN         (WR_EN),
    .WR_IDX        (WR_IDX),
    .WR_TIME       (WR_TIME),
    .WR_ENA        (WR_ENA),
    .ACK_STOP      (ACK_STOP),
    .ACK_SNOOZE    (ACK_SNOOZE),
    .ALARM_DOING   (ALARM_DOING),
    .ALARM_IDX     (ALARM_IDX),
    .SNOOZE_ACTIVE (SNOOZE_ACTIVE),
    .ENABLE_MASK   (ENABLE_MASK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_slot(input logic [1:0] idx, input logic [16:0] t, input logic ena);
    WR_EN   = 1'b1;
    WR_IDX  = idx;
    WR_TIME = t;
    WR_ENA  = ena;
    step();
    WR_EN   = 1'b0;
  endtask

  task automatic tick(input logic [16:0] t);
    SEC_TICK     = 1'b1;
    CURRENT_TIME = t;
    step();
    SEC_TICK     = 1'b0;
  endtask

  task automatic press(input logic stop, input logic snooze);
    ACK_STOP   = stop;
    ACK_SNOOZE = snooze;
    step();
    ACK_STOP   = 1'b0;
    ACK_SNOOZE = 1'b0;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    RESETN       = 1'b0;
    SEC_TICK     = 1'b0;
    CURRENT_TIME = '0;
    WR_EN        = 1'b0;
    WR_IDX       = '0;
    WR_TIME      = '0;
    WR_ENA       = 1'b0;
    ACK_STOP     = 1'b0;
    ACK_SNOOZE   = 1'b0;

    // Reset values
    step();
    step();
    chk("rst_doing", 32'(ALARM_DOING), 0);
    chk("rst_idx", 32'(ALARM_IDX), 0);
    chk("rst_snooze", 32'(SNOOZE_ACTIVE), 0);
    chk("rst_mask", 32'(ENABLE_MASK), 0);
    RESETN = 1'b1;
    step();

    // Slot 1 at 07:00 rings one cycle after the matching tick
    write_slot(2'd1, 17'd25200, 1'b1);
    chk("mask_s1", 32'(ENABLE_MASK), 32'h2);
    chk("pre_tick_doing", 32'(ALARM_DOING), 0);
    tick(17'd25200);
    chk("s1_doing", 32'(ALARM_DOING), 1);
    chk("s1_idx", 32'(ALARM_IDX), 1);
    chk("s1_snooze", 32'(SNOOZE_ACTIVE), 0);
    press(1'b1, 1'b0);
    chk("s1_stop", 32'(ALARM_DOING), 0);
    step();
    chk("s1_stay_idle", 32'(ALARM_DOING), 0);

    // Slots 0 and 2 coincide: lowest first, the other after one idle cycle
    write_slot(2'd0, 17'd3600, 1'b1);
    write_slot(2'd2, 17'd3600, 1'b1);
    chk("mask_012", 32'(ENABLE_MASK), 32'h7);
    tick(17'd3600);
    chk("dual_doing0", 32'(ALARM_DOING), 1);
    chk("dual_idx0", 32'(ALARM_IDX), 0);
    press(1'b1, 1'b0);
    chk("dual_gap", 32'(ALARM_DOING), 0);
    step();
    chk("dual_doing2", 32'(ALARM_DOING), 1);
    chk("dual_idx2", 32'(ALARM_IDX), 2);
    press(1'b1, 1'b0);
    chk("dual_stop2", 32'(ALARM_DOING), 0);
    step();
    chk("dual_empty", 32'(ALARM_DOING), 0);

    // Snooze for 300 ticks, then ring again on the same slot
    tick(17'd25200);
    chk("snz_ring", 32'(ALARM_DOING), 1);
    press(1'b0, 1'b1);
    chk("snz_active", 32'(SNOOZE_ACTIVE), 1);
    chk("snz_quiet", 32'(ALARM_DOING), 0);
    chk("snz_idx", 32'(ALARM_IDX), 1);
    for (int i = 0; i < 299; i++) begin
      tick(17'd100);
    end
    chk("snz_299_active", 32'(SNOOZE_ACTIVE), 1);
    chk("snz_299_quiet", 32'(ALARM_DOING), 0);
    tick(17'd100);
    chk("snz_300_doing", 32'(ALARM_DOING), 1);
    chk("snz_300_active", 32'(SNOOZE_ACTIVE), 0);
    chk("snz_300_idx", 32'(ALARM_IDX), 1);

    // Unattended ring stops after exactly 60 ticks
    for (int i = 0; i < 59; i++) begin
      tick(17'd100);
    end
    chk("to_59_doing", 32'(ALARM_DOING), 1);
    tick(17'd100);
    chk("to_60_doing", 32'(ALARM_DOING), 0);
    chk("to_60_snooze", 32'(SNOOZE_ACTIVE), 0);

    // Both keys at once: stop wins
    tick(17'd25200);
    chk("both_ring", 32'(ALARM_DOING), 1);
    press(1'b1, 1'b1);
    chk("both_doing", 32'(ALARM_DOING), 0);
    chk("both_snooze", 32'(SNOOZE_ACTIVE), 0);
    step();
    chk("both_snooze_hold", 32'(SNOOZE_ACTIVE), 0);

    // Stop coincident with a matching tick re-arms through PENDING
    tick(17'd25200);
    chk("rearm_ring", 32'(ALARM_DOING), 1);
    SEC_TICK     = 1'b1;
    CURRENT_TIME = 17'd25200;
    press(1'b1, 1'b0);
    SEC_TICK     = 1'b0;
    chk("rearm_stop", 32'(ALARM_DOING), 0);
    step();
    chk("rearm_doing", 32'(ALARM_DOING), 1);
    chk("rearm_idx", 32'(ALARM_IDX), 1);

    // Matches while ringing queue up; disabling slot 0 drops its pending bit
    tick(17'd3600);
    chk("q_still_s1", 32'(ALARM_IDX), 1);
    write_slot(2'd0, 17'd3600, 1'b0);
    chk("q_mask", 32'(ENABLE_MASK), 32'h6);
    chk("q_doing", 32'(ALARM_DOING), 1);
    press(1'b1, 1'b0);
    chk("q_gap", 32'(ALARM_DOING), 0);
    step();
    chk("q_next_doing", 32'(ALARM_DOING), 1);
    chk("q_next_idx", 32'(ALARM_IDX), 2);

    // Rewriting the active slot aborts the ring
    write_slot(2'd2, 17'd3600, 1'b1);
    chk("abort_doing", 32'(ALARM_DOING), 0);
    step();
    chk("abort_stays", 32'(ALARM_DOING), 0);

    // Asynchronous reset mid-ring, then out-of-range time rejected
    tick(17'd25200);
    chk("ar_ring", 32'(ALARM_DOING), 1);
    #3;
    RESETN = 1'b0;
    #1;
    chk("ar_doing", 32'(ALARM_DOING), 0);
    chk("ar_mask", 32'(ENABLE_MASK), 0);
    chk("ar_idx", 32'(ALARM_IDX), 0);
    #2;
    RESETN = 1'b1;
    step();
    write_slot(2'd0, 17'd86400, 1'b1);
    chk("bad_time_mask", 32'(ENABLE_MASK), 0);
    write_slot(2'd3, 17'd86399, 1'b1);
    chk("last_sec_mask", 32'(ENABLE_MASK), 32'h8);
    tick(17'd86399);
    chk("last_sec_doing", 32'(ALARM_DOING), 1);
    chk("last_sec_idx", 32'(ALARM_IDX), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
